// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, one writeback port, HI readout.
// The datapath side (decode/ALU) is master; the register file is slave.
interface reg_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   rs_addr;
    logic [ADDR_W-1:0]   rt_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en;
    logic                hi_wr_en;
    logic [2*DATA_W-1:0] wr_data;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic [DATA_W-1:0]   hi_data;

    modport master (
        output rs_addr,
        output rt_addr,
        output rd_addr,
        output wr_en,
        output hi_wr_en,
        output wr_data,
        input  rd_data_a,
        input  rd_data_b,
        input  hi_data
    );

    modport slave (
        input  rs_addr,
        input  rt_addr,
        input  rd_addr,
        input  wr_en,
        input  hi_wr_en,
        input  wr_data,
        output rd_data_a,
        output rd_data_b,
        output hi_data
    );
endinterface

// File: rtl/reg_file.sv
// Architectural GPR file with HI register: two async reads, one clocked write.
// GPR0 is hardwired zero; the upper half of the writeback can be captured in HI.
module reg_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] hi;
    logic              armed;
    logic              gpr_we;
    logic              hi_we;

    // armed stays low for the first edge after reset release, so a write
    // presented on the releasing edge is never taken, whatever the ordering.
    assign gpr_we = armed & bus.wr_en & (bus.rd_addr != '0);
    assign hi_we  = armed & bus.hi_wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
            hi    <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (gpr_we) begin
                gpr[bus.rd_addr] <= bus.wr_data[DATA_W-1:0];
            end
            if (hi_we) begin
                hi <= bus.wr_data[2*DATA_W-1:DATA_W];
            end
        end
    end

    // No write bypass: reads see stored state only, breaking the ALU loop.
    assign bus.rd_data_a = (bus.rs_addr == '0) ? '0 : gpr[bus.rs_addr];
    assign bus.rd_data_b = (bus.rt_addr == '0) ? '0 : gpr[bus.rt_addr];
    assign bus.hi_data   = hi;
endmodule
